ri_multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the R/I-type datapath (fetch, decode, execute units, register file).
- Replaces the single-cycle combinational control with an FSM that fetches over a req/ack handshake to a variable-latency instruction memory.
- Holds the instruction in an internal IR and decodes R/I-type fields.
- Pulses PC, IR, ALU-result and register-write enables in sequence, with fetch timeout, illegal-opcode trap and retired-instruction count.

---
 rtl/ri_multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ri_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ri_multicycle_ctrl.sv
// Multi-cycle sequencer for the R/I-type datapath: fetch over req/ack, decode, execute, writeback.
// Minimum four cycles per instruction. A stalled fetch traps after TIMEOUT cycles. Faults stick until reset.
module ri_multicycle_ctrl #(
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] Instruction_Code,
    output logic               imem_req,
    output logic [INSTR_W-1:0] IR_out,
    output logic               IR_Write,
    output logic               PC_Write,
    output logic               ALUOut_Write,
    output logic               RegWrite,
    output logic               Imm_Sel,
    output logic               ALU_Src,
    output logic [3:0]         ALU_op,
    output logic               busy,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [CNT_W-1:0]   retired
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [TO_W-1:0]    tcnt_inc;

    // Strobes are registered from the next state so they are glitch-free Moore outputs.
    logic req_q, req_d;
    logic alu_wr_q, alu_wr_d;
    logic wb_q, wb_d;
    logic busy_q, busy_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign tcnt_inc = tcnt_q + TO_W'(1);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        tcnt_d    = tcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A late ack in the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_d    = Instruction_Code;
                    tcnt_d  = '0;
                    state_d = S_DECODE;
                end else if (tcnt_inc == TO_W'(TIMEOUT)) begin
                    tcnt_d  = '0;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end else begin
                    tcnt_d  = tcnt_inc;
                end
            end
            S_DECODE: begin
                if (is_r || is_i) begin
                    state_d = S_EXECUTE;
                end else begin
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_d    = (state_d == S_FETCH);
        alu_wr_d = (state_d == S_EXECUTE);
        wb_d     = (state_d == S_WRITEBACK);
        busy_d   = (state_d != S_IDLE) && (state_d != S_TRAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
            tcnt_q    <= '0;
            req_q     <= 1'b0;
            alu_wr_q  <= 1'b0;
            wb_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            tcnt_q    <= tcnt_d;
            req_q     <= req_d;
            alu_wr_q  <= alu_wr_d;
            wb_q      <= wb_d;
            busy_q    <= busy_d;
        end
    end

    // Field decode follows the held IR so the datapath sees stable controls for the whole instruction.
    always_comb begin
        ALU_Src = 1'b0;
        Imm_Sel = 1'b0;
        ALU_op  = 4'b0000;
        if (is_r) begin
            ALU_op = {ir_q[30], funct3};
        end else if (is_i) begin
            ALU_Src = 1'b1;
            Imm_Sel = 1'b1;
            ALU_op  = {(funct3 == 3'b101) ? ir_q[30] : 1'b0, funct3};
        end
    end

    assign imem_req     = req_q;
    assign IR_Write     = req_q && imem_ack;
    assign ALUOut_Write = alu_wr_q;
    assign RegWrite     = wb_q;
    assign PC_Write     = wb_q;
    assign busy         = busy_q;
    assign trap         = trap_q;
    assign trap_cause   = cause_q;
    assign retired      = retired_q;
    assign IR_out       = ir_q;

endmodule

// File: tb/tb_ri_multicycle_ctrl.sv
// Bench for ri_multicycle_ctrl: directed instructions then randomized instruction/latency mix,
// checked per instruction against a transaction-level model of the sequencing rules.
module tb_ri_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_ack;
    logic [31:0] Instruction_Code;
    logic        imem_req;
    logic [31:0] IR_out;
    logic        IR_Write, PC_Write, ALUOut_Write, RegWrite;
    logic        Imm_Sel, ALU_Src;
    logic [3:0]  ALU_op;
    logic        busy, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ret_exp = '0;

    ri_multicycle_ctrl #(.INSTR_W(32), .CNT_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .imem_ack(imem_ack),
        .Instruction_Code(Instruction_Code), .imem_req(imem_req), .IR_out(IR_out),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .ALUOut_Write(ALUOut_Write),
        .RegWrite(RegWrite), .Imm_Sel(Imm_Sel), .ALU_Src(ALU_Src), .ALU_op(ALU_op),
        .busy(busy), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_legal(input logic [31:0] c);
        return (c[6:0] == 7'h33) || (c[6:0] == 7'h13);
    endfunction

    // {ALU_Src, Imm_Sel, ALU_op} from the instruction-format rules
    function automatic logic [5:0] dec_exp(input logic [31:0] c);
        logic [2:0] f3;
        f3 = c[14:12];
        if (c[6:0] == 7'h33) return {2'b00, c[30], f3};
        if (c[6:0] == 7'h13) return {2'b11, (f3 == 3'd5) ? c[30] : 1'b0, f3};
        return 6'd0;
    endfunction

    task automatic do_reset;
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; Instruction_Code = $urandom;
        #4;
        chk("rst_strobes", {imem_req, IR_Write, PC_Write, ALUOut_Write, RegWrite}, 0);
        chk("rst_status", {busy, trap, trap_cause}, 0);
        chk("rst_ir", IR_out, 0);
        chk("rst_retired", retired, 0);
        next_cyc;
        reset = 1'b0;
        ret_exp = '0;
    endtask

    task automatic start_run;
        run = 1'b1; imem_ack = 1'b0;
        #4;
        chk("idle_busy", {busy, imem_req}, 0);
        next_cyc;
    endtask

    task automatic hold_trap(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) begin
            run = 1'b1; imem_ack = 1'($urandom); Instruction_Code = $urandom;
            #4;
            chk("trap_quiet", {imem_req, IR_Write, PC_Write, ALUOut_Write, RegWrite, busy}, 0);
            chk("trap_sticky", {trap, trap_cause}, {1'b1, cause});
            next_cyc;
        end
    endtask

    // Entered one tick after the edge of a FETCH cycle. st: 0 back in FETCH, 1 idle, 2 trapped.
    // mode: 0 normal, 1 drop run during EXECUTE, 2 reset during EXECUTE.
    task automatic run_instr(input logic [31:0] code, input int delay, input int mode, output int st);
        bit acked = 1'b0;
        logic [5:0] d;
        for (int k = 0; k < TO && !acked; k++) begin
            imem_ack = (k == delay);
            Instruction_Code = (k == delay) ? code : $urandom;
            #4;
            chk("fetch_req", {imem_req, busy}, 2'b11);
            chk("fetch_irw", IR_Write, (k == delay));
            chk("fetch_wr", {PC_Write, RegWrite, ALUOut_Write}, 0);
            acked = (k == delay);
            next_cyc;
        end
        imem_ack = 1'b0; Instruction_Code = $urandom;
        if (!acked) begin
            #4;
            chk("to_trap", {trap, trap_cause, busy, imem_req}, {1'b1, 2'b10, 2'b00});
            chk("to_retired", retired, ret_exp);
            next_cyc;
            hold_trap(2'b10);
            st = 2;
            return;
        end
        #4;
        d = dec_exp(code);
        chk("dec_ir", IR_out, code);
        chk("dec_fields", {ALU_Src, Imm_Sel, ALU_op}, d);
        chk("dec_quiet", {imem_req, IR_Write, PC_Write, ALUOut_Write, RegWrite}, 0);
        next_cyc;
        if (!is_legal(code)) begin
            #4;
            chk("ill_trap", {trap, trap_cause, busy}, {1'b1, 2'b01, 1'b0});
            chk("ill_retired", retired, ret_exp);
            next_cyc;
            hold_trap(2'b01);
            st = 2;
            return;
        end
        if (mode == 1) run = 1'b0;
        #4;
        chk("exe_alu", {ALUOut_Write, RegWrite, PC_Write, busy}, 4'b1001);
        if (mode == 2) begin
            reset = 1'b1;
            #1;
            chk("exe_rst", {RegWrite, PC_Write, ALUOut_Write, busy, trap}, 0);
            chk("exe_rst_ret", retired, 0);
            chk("exe_rst_ir", IR_out, 0);
            next_cyc;
            #3;
            chk("exe_rst_hold", {RegWrite, PC_Write}, 0);
            reset = 1'b0; run = 1'b0; ret_exp = '0;
            next_cyc;
            st = 1;
            return;
        end
        next_cyc;
        #4;
        chk("wb_strobes", {RegWrite, PC_Write, ALUOut_Write, IR_Write, busy}, 5'b11001);
        ret_exp = ret_exp + 1;
        next_cyc;
        chk("wb_retired", retired, ret_exp);
        chk("wb_quiet", {RegWrite, PC_Write}, 0);
        if (run) begin
            chk("wb_next_fetch", {imem_req, busy}, 2'b11);
            st = 0;
        end else begin
            chk("wb_next_idle", {imem_req, busy}, 0);
            st = 1;
        end
    endtask

    task automatic recover(input int st);
        if (st == 2) do_reset;
        if (st != 0) start_run;
    endtask

    initial begin
        int st;
        logic [31:0] code;
        int kind, r, delay, mode;
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; Instruction_Code = '0;
        next_cyc;
        do_reset;
        start_run;

        run_instr(32'h00500093, 0, 0, st);
        chk("addi_fields", {ALU_Src, Imm_Sel, ALU_op}, 6'b11_0000);
        chk("addi_retired", retired, 1);
        run_instr(32'h402081B3, 0, 0, st);
        chk("sub_fields", {ALU_Src, Imm_Sel, ALU_op}, 6'b00_1000);
        run_instr(32'h002081B3, 1, 0, st);
        chk("add_fields", {ALU_Src, Imm_Sel, ALU_op}, 6'b00_0000);
        run_instr(32'h40335293, TO - 1, 0, st);
        chk("srai_fields", {ALU_Src, Imm_Sel, ALU_op}, 6'b11_1101);
        chk("srai_retired", retired, 4);
        run_instr(32'h00500093, TO, 0, st);
        recover(st);
        run_instr(32'h00000000, 0, 0, st);
        recover(st);
        run_instr(32'h002081B3, 2, 1, st);
        chk("drop_run_idle", {busy, imem_req}, 0);
        recover(st);
        run_instr(32'h002081B3, 0, 2, st);
        recover(st);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            code = $urandom;
            if (kind < 4) code[6:0] = 7'h33;
            else if (kind < 8) code[6:0] = 7'h13;
            else if (kind == 8) code = '0;
            else if (is_legal(code)) code[0] = ~code[0];
            r = $urandom_range(0, 19);
            delay = (r < 16) ? (r % TO) : (TO + r % 2);
            r = $urandom_range(0, 15);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            run_instr(code, delay, mode, st);
            recover(st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
